// File: rtl/shift_serializer8.sv
// shift_serializer8 -- parallel-to-serial transmitter.
//
// Accepts one WIDTH-bit word per input valid/ready handshake and emits it one
// bit per accepted output beat, flagging the final bit with io_out_last.
// A new word can be taken on the last beat of the current one, so back-to-back
// words stream with no idle beat between them.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   reset         in   synchronous reset, active low
//   io_in_valid   in   parallel word offered
//   io_in_ready   out  word accepted this cycle (0 while reset is low)
//   io_in_bits    in   parallel word, WIDTH bits
//   io_out_valid  out  io_out_bit holds a valid beat
//   io_out_ready  in   downstream takes the current beat
//   io_out_bit    out  current serial bit
//   io_out_last   out  current bit is the final bit of the word
module shift_serializer8 #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic             io_out_bit,
  output logic             io_out_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] shreg_shifted;

  assign io_out_valid = (state_q == SHIFT);
  assign io_out_bit   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign io_out_last  = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // Ready is combinational on io_out_ready so the next word can be captured
  // in the same cycle the last bit of the current word is consumed.
  assign io_in_ready  = reset && ((state_q == IDLE) || (io_out_last && io_out_ready));

  assign in_fire  = io_in_valid && io_in_ready;
  assign out_fire = io_out_valid && io_out_ready;

  // Move the next bit toward the output end, zero filling behind it.
  assign shreg_shifted = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                   : {shreg_q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          shreg_d = io_in_bits;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_fire) begin
          if (io_out_last) begin
            if (in_fire) begin
              shreg_d = io_in_bits;
              cnt_d   = '0;
              state_d = SHIFT;
            end else begin
              // Clearing the register keeps io_out_bit at 0 while idle.
              shreg_d = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_serializer8.sv
// Directed bench for shift_serializer8: one LSB-first and one MSB-first
// instance, expected bit sequences written out by hand.
module tb_shift_serializer8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready, out_bit, out_last;
  logic [7:0] in_bits;
  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_bit, m_out_last;
  logic [7:0] m_in_bits;

  int n_checks = 0;
  int n_fail   = 0;

  shift_serializer8 #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_bits(in_bits),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_bit(out_bit), .io_out_last(out_last)
  );

  shift_serializer8 #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset),
    .io_in_valid(m_in_valid), .io_in_ready(m_in_ready), .io_in_bits(m_in_bits),
    .io_out_valid(m_out_valid), .io_out_ready(m_out_ready),
    .io_out_bit(m_out_bit), .io_out_last(m_out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One beat of the LSB-first instance: outputs checked mid-cycle.
  task automatic beat(input string tag, input logic eb, input logic el);
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".bit"},   32'(out_bit),   32'(eb));
    check({tag, ".last"},  32'(out_last),  32'(el));
    check({tag, ".ready"}, 32'(in_ready),  32'(el & out_ready));
    cyc();
  endtask

  task automatic load(input string tag, input logic [7:0] word);
    in_valid = 1'b1;
    in_bits  = word;
    @(negedge clk);
    check({tag, ".accept"}, 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".bit"},   32'(out_bit),   32'd0);
    check({tag, ".last"},  32'(out_last),  32'd0);
    check({tag, ".ready"}, 32'(in_ready),  32'd1);
    cyc();
  endtask

  logic [0:7]  seq8;
  logic [0:15] seq16;

  initial begin
    reset = 1'b0; in_valid = 1'b1; in_bits = 8'hFF; out_ready = 1'b1;
    m_in_valid = 1'b0; m_in_bits = 8'h00; m_out_ready = 1'b1;

    // 1: reset held two cycles with a word offered
    cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("t1.rst%0d.ready", i), 32'(in_ready), 32'd0);
      check($sformatf("t1.rst%0d.valid", i), 32'(out_valid), 32'd0);
      cyc();
    end
    reset = 1'b1; in_valid = 1'b0;
    idle_check("t1.post0");
    idle_check("t1.post1");

    // 2: 0xC1, continuous ready
    load("t2", 8'hC1);
    seq8 = 8'b1000_0011;
    for (int i = 0; i < 8; i++) beat($sformatf("t2.b%0d", i + 1), seq8[i], i == 7);
    idle_check("t2.end");

    // 3: 0x01 then 0x80 streamed back to back
    load("t3", 8'h01);
    in_valid = 1'b1; in_bits = 8'h80;
    seq16 = 16'b1000_0000_0000_0001;
    for (int i = 0; i < 16; i++) begin
      beat($sformatf("t3.b%0d", i + 1), seq16[i], (i == 7) || (i == 15));
      if (i == 7) in_valid = 1'b0;
    end
    idle_check("t3.end");

    // 4: 0x0F with a three-cycle stall after beat 2
    load("t4", 8'h0F);
    beat("t4.b1", 1'b1, 1'b0);
    beat("t4.b2", 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat($sformatf("t4.stall%0d", i), 1'b1, 1'b0);
    out_ready = 1'b1;
    seq8 = 8'b1100_0000;
    for (int i = 0; i < 6; i++) beat($sformatf("t4.b%0d", i + 3), seq8[i], i == 5);
    idle_check("t4.end");

    // 5: reset mid-word, then a fresh word
    load("t5", 8'hFF);
    for (int i = 0; i < 3; i++) beat($sformatf("t5.b%0d", i + 1), 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("t5.rst.ready", 32'(in_ready), 32'd0);
    cyc();
    reset = 1'b1;
    idle_check("t5.abort");
    load("t5b", 8'h3C);
    seq8 = 8'b0011_1100;
    for (int i = 0; i < 8; i++) beat($sformatf("t5b.b%0d", i + 1), seq8[i], i == 7);
    idle_check("t5b.end");

    // 6: MSB-first instance, 0x0F
    m_in_valid = 1'b1; m_in_bits = 8'h0F;
    @(negedge clk);
    check("t6.accept", 32'(m_in_ready), 32'd1);
    cyc();
    m_in_valid = 1'b0;
    seq8 = 8'b0000_1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t6.b%0d.valid", i + 1), 32'(m_out_valid), 32'd1);
      check($sformatf("t6.b%0d.bit", i + 1),   32'(m_out_bit),   32'(seq8[i]));
      check($sformatf("t6.b%0d.last", i + 1),  32'(m_out_last),  32'(i == 7));
      cyc();
    end
    @(negedge clk);
    check("t6.end.valid", 32'(m_out_valid), 32'd0);
    check("t6.end.ready", 32'(m_in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
